// File: rtl/ap_result_collector.sv
// Purpose : packs dot-product result elements into rows of no_of_units lanes and
//           buffers the rows in a small FIFO for a downstream consumer.
// Latency : 1 cycle from the accepted element that completes a row to row_valid (empty FIFO).
// Backpr. : accept_ready drops while the FIFO is full or the pass is done; the head row
//           holds on row_out until row_valid && row_ready.
//
// Ports:
//   clk, reset          - single rising-edge clock, synchronous active-high reset
//   total               - elements in this pass, captured while reset is high
//   result, AP_total_mem_we - element and its one-cycle write strobe from the producer
//   accept_ready        - producer may issue strobes (feeds its outsider_read_now)
//   row_out, row_valid, row_ready - packed row stream, lane 0 in the LSBs
//   rows_collected      - number of rows pushed into the FIFO (wraps at 2^32)
//   done                - sticky: all elements accepted and FIFO drained
//   overflow_err        - sticky strobe-while-not-ready flag
//
// Optional feature: define AP_COLLECT_OVERFLOW_FLAG_EN to build the overflow detector;
// without it overflow_err is tied low.
module ap_result_collector #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int fifo_depth    = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [31:0]                          total,
    input  logic [element_width-1:0]             result,
    input  logic                                 AP_total_mem_we,
    output logic                                 accept_ready,
    output logic [element_width*no_of_units-1:0] row_out,
    output logic                                 row_valid,
    input  logic                                 row_ready,
    output logic [31:0]                          rows_collected,
    output logic                                 done,
    output logic                                 overflow_err
);

    localparam int ROW_W  = element_width * no_of_units;
    localparam int PTR_W  = $clog2(fifo_depth);
    localparam int OCC_W  = PTR_W + 1;
    localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;

    logic [LANE_W-1:0] lane_idx;
    logic [31:0]       elem_cnt;
    logic [31:0]       total_q;
    logic [31:0]       row_cnt;
    logic [ROW_W-1:0]  asm_row;
    logic [ROW_W-1:0]  asm_next;
    logic [ROW_W-1:0]  mem [fifo_depth];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    logic fifo_empty;
    logic fifo_full;
    logic pass_done;
    logic accept;
    logic last_elem;
    logic lane_last;
    logic push;
    logic pop;

    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == OCC_W'(fifo_depth));

    // Pass completion is a pure function of registered state; once true nothing can
    // change elem_cnt or occ again, so it stays set until the next reset.
    assign pass_done = (elem_cnt == total_q) && fifo_empty;

    // Outputs are forced to zero for the whole reset cycle so a mid-pass reset
    // discards buffered rows immediately, not one cycle later.
    assign accept_ready   = !reset && !fifo_full && !pass_done;
    assign done           = !reset && pass_done;
    assign row_valid      = !reset && !fifo_empty;
    assign row_out        = row_valid ? mem[rd_ptr] : '0;
    assign rows_collected = reset ? '0 : row_cnt;

    // Strobes beyond the expected count (while the last rows drain) are dropped so
    // the element count can never overrun total.
    assign accept    = AP_total_mem_we && accept_ready && (elem_cnt != total_q);
    assign last_elem = ((elem_cnt + 32'd1) == total_q);
    assign lane_last = (lane_idx == LANE_W'(no_of_units - 1));
    assign push      = accept && (lane_last || last_elem);
    assign pop       = row_valid && row_ready;

    // Assembly register with the incoming element merged into its lane; lanes not yet
    // written are still zero because the register is cleared after every push.
    always_comb begin
        asm_next = asm_row;
        asm_next[int'(lane_idx)*element_width +: element_width] = result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q  <= total;
            lane_idx <= '0;
            elem_cnt <= '0;
            asm_row  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            row_cnt  <= '0;
        end else begin
            if (accept) begin
                elem_cnt <= elem_cnt + 32'd1;
                if (push) begin
                    asm_row  <= '0;
                    lane_idx <= '0;
                end else begin
                    asm_row  <= asm_next;
                    lane_idx <= lane_idx + 1'b1;
                end
            end
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                row_cnt <= row_cnt + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Row storage needs no reset: entries are only visible once written and counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= asm_next;
        end
    end

`ifdef AP_COLLECT_OVERFLOW_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (AP_total_mem_we && !accept_ready && !pass_done) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow_err = !reset && ovf_q;
`else
    assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_ap_result_collector.sv
// Purpose : self-checking bench for ap_result_collector (default parameters).
// Latency : n/a (bench).
// Backpr. : drives random row_ready stalls and strobes against a queue-based row model.
module tb_ap_result_collector;

    localparam int EW = 32;
    localparam int N  = 8;
    localparam int D  = 4;
    localparam int RW = EW * N;

`ifdef AP_COLLECT_OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   total;
    logic [EW-1:0] result;
    logic          we;
    logic          rr;
    logic          ar;
    logic [RW-1:0] row_out;
    logic          rv;
    logic [31:0]   rows;
    logic          done;
    logic          ovf;

    always #5 clk = ~clk;

    ap_result_collector #(
        .element_width(EW),
        .no_of_units  (N),
        .fifo_depth   (D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .total          (total),
        .result         (result),
        .AP_total_mem_we(we),
        .accept_ready   (ar),
        .row_out        (row_out),
        .row_valid      (rv),
        .row_ready      (rr),
        .rows_collected (rows),
        .done           (done),
        .overflow_err   (ovf)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: rows waiting in the FIFO, elements of the row being built,
    // accepted element count, rows pushed, sticky overflow.
    logic [RW-1:0] m_fifo[$];
    logic [EW-1:0] m_cur[$];
    int unsigned   m_tot;
    int unsigned   m_acc;
    logic [31:0]   m_rows;
    logic          m_ovf;
    logic [RW-1:0] got[$];
    int unsigned   seq;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic m_done();
        return (m_acc == m_tot) && (m_fifo.size() == 0);
    endfunction

    // One cycle: compare outputs against the model, then advance the model with the
    // inputs the DUT will sample at the coming rising edge.
    task automatic step();
        logic          e_done;
        logic          e_ar;
        logic          e_rv;
        logic [RW-1:0] e_row;
        logic [RW-1:0] row;
        #1;
        e_done = !reset && m_done();
        e_ar   = !reset && (m_fifo.size() < D) && !e_done;
        e_rv   = !reset && (m_fifo.size() > 0);
        e_row  = e_rv ? m_fifo[0] : '0;
        chk("accept_ready", RW'(ar), RW'(e_ar));
        chk("row_valid", RW'(rv), RW'(e_rv));
        chk("row_out", row_out, e_row);
        chk("rows_collected", RW'(rows), RW'(reset ? 32'd0 : m_rows));
        chk("done", RW'(done), RW'(e_done));
        chk("overflow_err", RW'(ovf), RW'(!reset && m_ovf));
        if (rv && rr) got.push_back(row_out);
        if (reset) begin
            m_fifo.delete();
            m_cur.delete();
            m_tot  = total;
            m_acc  = 0;
            m_rows = '0;
            m_ovf  = 1'b0;
            got.delete();
        end else begin
            if (OVF_EN && we && !e_ar && !e_done) m_ovf = 1'b1;
            if (e_rv && rr) void'(m_fifo.pop_front());
            if (we && e_ar && (m_acc < m_tot)) begin
                m_cur.push_back(result);
                m_acc++;
                if (m_cur.size() == N || m_acc == m_tot) begin
                    row = '0;
                    foreach (m_cur[i]) row[i*EW +: EW] = m_cur[i];
                    m_fifo.push_back(row);
                    m_rows++;
                    m_cur.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned t);
        reset = 1'b1;
        we    = 1'b0;
        rr    = 1'b0;
        total = t;
        step();
        step();
        reset = 1'b0;
        seq   = 1;
    endtask

    // Strobe/stall with the given percentages until the model says the pass is done.
    task automatic run(input int p_we, input int p_rr, input int maxc, input bit seqdata);
        for (int c = 0; c < maxc; c++) begin
            if (m_done()) break;
            we     = (m_acc < m_tot) && ($urandom_range(99) < p_we);
            result = seqdata ? EW'(seq) : EW'($urandom);
            if (we) seq++;
            rr = ($urandom_range(99) < p_rr);
            step();
        end
        we = 1'b0;
        #1;
        chk("pass_complete", RW'(done), RW'(1'b1));
    endtask

    function automatic logic [RW-1:0] lanes(input int first, input int count);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < count; i++) r[i*EW +: EW] = EW'(first + i);
        return r;
    endfunction

    initial begin
        reset  = 1'b1;
        we     = 1'b0;
        rr     = 1'b0;
        result = '0;
        total  = '0;
        seq    = 1;
        m_tot  = 0;
        m_acc  = 0;
        m_rows = '0;
        m_ovf  = 1'b0;
        @(negedge clk);

        // total=16, back-to-back strobes, consumer always ready.
        do_reset(16);
        for (int i = 1; i <= 16; i++) begin
            we     = 1'b1;
            result = EW'(i);
            rr     = 1'b1;
            step();
            if (i == 7) chk("rv_before_8th", RW'(rv), RW'(1'b0));
            if (i == 8) chk("rv_after_8th", RW'(rv), RW'(1'b1));
            if (i == 16) chk("rv_after_16th", RW'(rv), RW'(1'b1));
        end
        we = 1'b0;
        run(0, 100, 50, 1'b1);
        chk("t16_rows", RW'(rows), RW'(32'd2));
        chk("t16_row0", (got.size() > 0) ? got[0] : '0, lanes(1, 8));
        chk("t16_row1", (got.size() > 1) ? got[1] : '0, lanes(9, 8));

        // total=10: partial last row is zero-filled.
        do_reset(10);
        run(100, 100, 200, 1'b1);
        chk("t10_rows", RW'(rows), RW'(32'd2));
        chk("t10_row1", (got.size() > 1) ? got[1] : '0, lanes(9, 2));

        // total=48 with consumer stalled: four rows fill the FIFO.
        do_reset(48);
        for (int i = 0; i < 40; i++) begin
            we     = 1'b1;
            result = EW'(seq);
            seq++;
            rr     = 1'b0;
            step();
        end
        chk("t48_full_rows", RW'(rows), RW'(32'd4));
        chk("t48_full_ar", RW'(ar), RW'(1'b0));
        chk("t48_overflow", RW'(ovf), RW'(OVF_EN));
        we = 1'b0;
        rr = 1'b1;
        step();
        chk("t48_ar_after_pop", RW'(ar), RW'(1'b1));
        // Push and pop together while near full; model checks data order.
        for (int i = 0; i < 6; i++) begin
            we     = 1'b1;
            result = EW'(seq);
            seq++;
            rr     = 1'b1;
            step();
        end
        run(100, 100, 500, 1'b1);
        chk("t48_rows", RW'(rows), RW'(32'd6));
        chk("t48_overflow_sticky", RW'(ovf), RW'(OVF_EN));

        // Reset pulsed after 5 of 16 elements, then a fresh pass.
        do_reset(16);
        for (int i = 0; i < 5; i++) begin
            we     = 1'b1;
            result = EW'(seq);
            seq++;
            rr     = 1'b1;
            step();
        end
        reset = 1'b1;
        we    = 1'b0;
        step();
        reset = 1'b0;
        seq   = 1;
        #1;
        chk("mid_rst_rows", RW'(rows), RW'(32'd0));
        chk("mid_rst_rv", RW'(rv), RW'(1'b0));
        chk("mid_rst_done", RW'(done), RW'(1'b0));
        run(100, 100, 200, 1'b1);
        chk("mid_rst_rows_after", RW'(rows), RW'(32'd2));
        chk("mid_rst_row0", (got.size() > 0) ? got[0] : '0, lanes(1, 8));

        // total=0: done on the first cycle after reset, no rows.
        do_reset(0);
        #1;
        chk("t0_done", RW'(done), RW'(1'b1));
        chk("t0_rows", RW'(rows), RW'(32'd0));
        rr = 1'b1;
        step();
        step();

        // Randomized passes with random strobes, data and consumer stalls.
        for (int p = 0; p < 10; p++) begin
            do_reset($urandom_range(1, 45));
            run($urandom_range(30, 100), $urandom_range(20, 100), 3000, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
